vga_frame_writer: RTL

Fills the SRAM frame buffer that the 800x600 VGA display path reads. It accepts a stream of RGB888 pixels with a valid/ready handshake and a start-of-frame marker, and packs each pixel to RGB565. It writes each pixel to the row-major SRAM address and keeps writes off the SRAM while the display path owns it (`sram_busy`). It sits between the pixel source (UART loader, test-pattern generator) and the shared SRAM write port.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_frame_writer_if.sv | 23 ++
 rtl/rgb888_to_rgb565.sv | 13 +
 rtl/vga_frame_writer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, writer FSM encoding and RGB565 field layout.
package vga_pkg;

    localparam int H_DISPLAY_800 = 800;
    localparam int V_DISPLAY_600 = 600;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } fbw_state_t;

    localparam int R565_MSB = 15;
    localparam int R565_LSB = 11;
    localparam int G565_MSB = 10;
    localparam int G565_LSB = 5;
    localparam int B565_MSB = 4;
    localparam int B565_LSB = 0;

endpackage

// File: rtl/vga_frame_writer_if.sv
// Pixel stream and SRAM write port of the frame writer.
interface vga_frame_writer_if #(
    parameter int ADDR_W = 20
);
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic [23:0]       pix_data;
    logic              sram_busy;
    logic [ADDR_W-1:0] sram_address;
    logic [15:0]       sram_wdata;
    logic              sram_we;

    modport master (
        output pix_valid, pix_sof, pix_data, sram_busy,
        input  pix_ready, sram_address, sram_wdata, sram_we
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data, sram_busy,
        output pix_ready, sram_address, sram_wdata, sram_we
    );
endinterface

// File: rtl/rgb888_to_rgb565.sv
// Combinational RGB888 -> RGB565 pack (truncating each channel to its MSBs).
module rgb888_to_rgb565
    import vga_pkg::*;
(
    input  logic [23:0] rgb888,
    output logic [15:0] rgb565
);

    assign rgb565[R565_MSB:R565_LSB] = rgb888[23:19];
    assign rgb565[G565_MSB:G565_LSB] = rgb888[15:10];
    assign rgb565[B565_MSB:B565_LSB] = rgb888[7:3];

endmodule

// File: rtl/vga_frame_writer.sv
// Streams RGB888 pixels into the row-major RGB565 SRAM frame buffer.
// Optional statistics counters are built when VGA_FBW_STATS_EN is defined.
module vga_frame_writer
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_800,
    parameter int V_DISPLAY = V_DISPLAY_600,
    parameter int ADDR_W    = 20
) (
    input  logic               clk,
    input  logic               reset,
    vga_frame_writer_if.slave  bus,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic [7:0]         sync_err_count
);

    localparam int X_W = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
    localparam int Y_W = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;

    fbw_state_t        state_reg;
    logic [X_W-1:0]    x_reg;
    logic [Y_W-1:0]    y_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] sram_address_reg;
    logic [15:0]       sram_wdata_reg;
    logic              sram_we_reg;
    logic              frame_done_reg;

    logic [15:0] rgb565;
    logic        xfer;
    logic        restart;
    logic        at_eol;
    logic        at_last;
    logic        last_write;

    rgb888_to_rgb565 u_pack (
        .rgb888 (bus.pix_data),
        .rgb565 (rgb565)
    );

    // Ready never looks at valid, so sources may wait on it without deadlock.
    assign bus.pix_ready = !reset && !bus.sram_busy;
    assign xfer          = bus.pix_valid && bus.pix_ready;
    assign restart       = xfer && bus.pix_sof;
    assign at_eol        = (x_reg == X_W'(H_DISPLAY - 1));
    assign at_last       = at_eol && (y_reg == Y_W'(V_DISPLAY - 1));
    assign last_write    = xfer && !bus.pix_sof && (state_reg == WRITE) && at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            x_reg            <= '0;
            y_reg            <= '0;
            addr_reg         <= '0;
            sram_address_reg <= '0;
            sram_wdata_reg   <= '0;
            sram_we_reg      <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            sram_we_reg    <= 1'b0;
            frame_done_reg <= last_write;
            // SOF always wins, including over a coincident last-pixel position.
            if (restart) begin
                sram_address_reg <= '0;
                sram_wdata_reg   <= rgb565;
                sram_we_reg      <= 1'b1;
                x_reg            <= X_W'(1);
                y_reg            <= '0;
                addr_reg         <= ADDR_W'(1);
                state_reg        <= WRITE;
            end else if (xfer && state_reg == WRITE) begin
                sram_address_reg <= addr_reg;
                sram_wdata_reg   <= rgb565;
                sram_we_reg      <= 1'b1;
                addr_reg         <= addr_reg + ADDR_W'(1);
                if (at_eol) begin
                    x_reg <= '0;
                    if (at_last) begin
                        y_reg     <= '0;
                        addr_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        y_reg <= y_reg + Y_W'(1);
                    end
                end else begin
                    x_reg <= x_reg + X_W'(1);
                end
            end
        end
    end

    assign bus.sram_address = sram_address_reg;
    assign bus.sram_wdata   = sram_wdata_reg;
    assign bus.sram_we      = sram_we_reg;
    assign frame_done       = frame_done_reg;

`ifdef VGA_FBW_STATS_EN
    logic [15:0] frame_count_reg;
    logic [7:0]  sync_err_count_reg;
    logic        premature;

    assign premature = restart && (state_reg == WRITE) && ((x_reg != '0) || (y_reg != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_reg    <= '0;
            sync_err_count_reg <= '0;
        end else begin
            if (last_write)
                frame_count_reg <= frame_count_reg + 16'd1;
            if (premature && sync_err_count_reg != 8'hFF)
                sync_err_count_reg <= sync_err_count_reg + 8'd1;
        end
    end

    assign frame_count    = frame_count_reg;
    assign sync_err_count = sync_err_count_reg;
`else
    assign frame_count    = '0;
    assign sync_err_count = '0;
`endif

endmodule
